multiword_add_seq: RTL and testbench

//  Sequential wide adder: accepts two W=N*WORDS-bit operands, adds them N bits per cycle

---
 rtl/mwadd_pkg.sv | 21 ++
 rtl/adder_chunk.sv | 29 ++
 rtl/multiword_add_seq.sv | 139 +++++++++++++
 tb/tb_multiword_add_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mwadd_pkg.sv
// Shared definitions for the sequential multi-word adder.
//   state_e : FSM encoding (IDLE -> ADD -> DONE -> IDLE)
//   N_DEF / WORDS_DEF : default chunk width and chunk count
//   idx_w() : width of the chunk index register (at least 1 bit)
package mwadd_pkg;

    localparam int N_DEF     = 8;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // WORDS=1 still needs a 1-bit index so the register has a legal width.
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational N-bit ripple-carry adder used as the shared chunk datapath.
// Ports:
//   cin  in  1  carry into bit 0
//   a    in  N  operand chunk A
//   b    in  N  operand chunk B
//   s    out N  sum chunk
//   cout out 1  carry out of bit N-1
module adder_chunk #(
    parameter int N = 8
) (
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: W = N*WORDS bit operands are added one N-bit chunk
// per cycle through a single adder_chunk, with the carry registered between
// chunks. Latency: WORDS ADD cycles after the accept edge; one add per
// WORDS+2 cycles including the IDLE accept and DONE handoff cycles.
// Optional feature macro: MWADD_SUB_EN (adds the 'sub' port, computes A-B).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a, b, carry_in      operands and carry into chunk 0
//   sub                 subtract select (MWADD_SUB_EN only)
//   out_valid/out_ready result handshake (valid only in DONE)
//   sum, carry_out      W-bit result and carry out of the top chunk
module multiword_add_seq
    import mwadd_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic             carry_in,
`ifdef MWADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic             carry_out
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             creg_q,  creg_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             sub_q,   sub_d;

    logic [N-1:0] ch_a, ch_b, ch_s;
    logic         ch_cout;
    logic         cin_eff;
    logic         sub_in;

`ifdef MWADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction is A + ~B + 1; the incoming carry is overridden.
    assign cin_eff = sub_in ? 1'b1 : carry_in;

    assign ch_a = a_q[idx_q*N +: N];
    assign ch_b = sub_q ? ~b_q[idx_q*N +: N] : b_q[idx_q*N +: N];

    adder_chunk #(.N(N)) u_chunk (
        .cin  (creg_q),
        .a    (ch_a),
        .b    (ch_b),
        .s    (ch_s),
        .cout (ch_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        creg_d  = creg_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    creg_d  = cin_eff;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Only the current chunk is overwritten; higher chunks keep
                // stale data until their cycle comes.
                sum_d[idx_q*N +: N] = ch_s;
                creg_d              = ch_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = ch_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            creg_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            creg_q  <= creg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks = 0;
    int errors = 0;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef MWADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_carry_out", 64'(carry_out), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Full-width carry ripple: FFFFFFFF + 1.
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; carry_in = 1'b0; in_valid = 1'b1;
        step();                              // accept edge
        in_valid = 1'b0;
        chk("t1_busy_in_ready", 64'(in_ready), 64'd0);
        for (int k = 1; k < WORDS; k++) begin
            step();
            chk($sformatf("t1_early_valid_%0d", k), 64'(out_valid), 64'd0);
        end
        step();                              // WORDS edges after accept
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_sum",       64'(sum),       64'h0000_0000);
        chk("t1_carry_out", 64'(carry_out), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_handoff_valid", 64'(out_valid), 64'd0);
        chk("t1_handoff_ready", 64'(in_ready),  64'd1);

        // 12345678 + 11111111 + 1 with 10 cycles of backpressure.
        a = 32'h1234_5678; b = 32'h1111_1111; carry_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; carry_in = 1'b0;
        repeat (WORDS) step();
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_sum",       64'(sum),       64'h2345_678A);
        chk("t2_carry_out", 64'(carry_out), 64'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp_sum_%0d", k),   64'(sum),       64'h2345_678A);
            chk($sformatf("bp_ready_%0d", k), 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready),  64'd1);

        // Reset during chunk 2 of 11111111 + 22222222.
        a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();                              // chunks 0 and 1 written
        chk("mid_partial_sum", 64'(sum), 64'h2345_3333);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd1);
        chk("mid_rst_sum",   64'(sum),       64'd0);
        step();
        rst_n = 1'b1;
        a = 32'h0000_0001; b = 32'h0000_0002; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (WORDS) step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_sum",   64'(sum),       64'h0000_0003);
        chk("post_rst_cout",  64'(carry_out), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Back-to-back with in_valid held high and out_ready held high.
        out_ready = 1'b1;
        a = 32'h0000_00FF; b = 32'h0000_0001; carry_in = 1'b0; in_valid = 1'b1;
        step();                              // first accept
        a = 32'h8000_0000; b = 32'h8000_0000; carry_in = 1'b1;
        for (int k = 1; k < WORDS; k++) begin
            step();
            chk($sformatf("b2b_busy_%0d", k), 64'(in_ready), 64'd0);
        end
        step();
        chk("b2b_r1_valid", 64'(out_valid), 64'd1);
        chk("b2b_r1_sum",   64'(sum),       64'h0000_0100);
        chk("b2b_r1_cout",  64'(carry_out), 64'd0);
        chk("b2b_r1_ready", 64'(in_ready),  64'd0);
        step();                              // handoff edge; nothing accepted
        chk("b2b_idle_ready", 64'(in_ready),  64'd1);
        chk("b2b_idle_valid", 64'(out_valid), 64'd0);
        step();                              // second accept
        in_valid = 1'b0; carry_in = 1'b0;
        chk("b2b_second_busy", 64'(in_ready), 64'd0);
        repeat (WORDS) step();
        chk("b2b_r2_valid", 64'(out_valid), 64'd1);
        chk("b2b_r2_sum",   64'(sum),       64'h0000_0001);
        chk("b2b_r2_cout",  64'(carry_out), 64'd1);
        step();
        out_ready = 1'b0;
        chk("b2b_r2_done", 64'(out_valid), 64'd0);

`ifdef MWADD_SUB_EN
        // 5 - 7 borrows; 7 - 5 does not. carry_in is ignored when subtracting.
        a = 32'h0000_0005; b = 32'h0000_0007; sub = 1'b1; carry_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; sub = 1'b0;
        repeat (WORDS) step();
        chk("sub1_valid", 64'(out_valid), 64'd1);
        chk("sub1_sum",   64'(sum),       64'hFFFF_FFFE);
        chk("sub1_cout",  64'(carry_out), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        a = 32'h0000_0007; b = 32'h0000_0005; sub = 1'b1; carry_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; sub = 1'b0; carry_in = 1'b0;
        repeat (WORDS) step();
        chk("sub2_valid", 64'(out_valid), 64'd1);
        chk("sub2_sum",   64'(sum),       64'h0000_0002);
        chk("sub2_cout",  64'(carry_out), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
